// File: rtl/pattern_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// pattern_scan_ctrl_if
// Bundles the configuration, input-word and count-report handshakes of the
// pattern scan controller.
//   cfg_load / cfg_pattern : pattern reload request (honoured in IDLE only)
//   in_valid / in_ready / in_data     : word producer handshake
//   out_valid / out_ready / out_count : match-count report handshake
//   match : registered Moore match flag, busy : SHIFT or REPORT
// slave  = controller side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface pattern_scan_ctrl_if #(
   parameter int WORD_W = 8,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 4
);
   logic              cfg_load;
   logic [PAT_W-1:0]  cfg_pattern;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  out_count;
   logic              match;
   logic              busy;

   modport slave (
      input  cfg_load, cfg_pattern, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_count, match, busy
   );

   modport master (
      output cfg_load, cfg_pattern, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_count, match, busy
   );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// pattern_scan_ctrl
// Word-serial scan controller. Accepts a WORD_W-bit word, shifts it MSB-first
// through a PAT_W-bit history register one bit per cycle, counts the bits
// that complete a match against the programmed pattern, then reports the
// count over a valid/ready handshake.
// Ports:
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : pattern_scan_ctrl_if.slave (cfg, input word, count report,
//           match flag, busy)
// History and fill persist across words so patterns spanning a word
// boundary are detected; only reset or an accepted cfg_load clears them.
// ---------------------------------------------------------------------------
module pattern_scan_ctrl #(
   parameter int WORD_W = 8,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 4
) (
   input  logic                clk,
   input  logic                n_rst,
   pattern_scan_ctrl_if.slave  bus
);
   localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [PAT_W-1:0]  PAT_RST   = PAT_W'(4'b1101);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_REPORT = 2'd2
   } state_t;

   state_t            r_state;
   logic [PAT_W-1:0]  r_pattern;
   logic [PAT_W-1:0]  r_hist;
   logic [FILL_W-1:0] r_fill;
   logic [CNT_W-1:0]  r_count;
   logic [WORD_W-1:0] r_word;
   logic [IDX_W-1:0]  r_bit_idx;
   logic              r_match;
   logic              r_out_valid;
   logic              r_busy;

   logic              w_bit;
   logic [PAT_W-1:0]  w_next_hist;
   logic [FILL_W-1:0] w_next_fill;
   logic              w_hit;
   logic              w_accept;

   // Next history / fill as they will be after shifting the current bit.
   // The cast drops the oldest bit off the MSB end.
   assign w_bit       = r_word[r_bit_idx];
   assign w_next_hist = PAT_W'({r_hist, w_bit});
   assign w_next_fill = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
   assign w_hit       = (w_next_fill == FILL_FULL) && (w_next_hist == r_pattern);
   assign w_accept    = (r_state == S_IDLE) && bus.in_valid;

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.out_count = r_count;
   assign bus.match     = r_match;
   assign bus.busy      = r_busy;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state     <= S_IDLE;
         r_pattern   <= PAT_RST;
         r_hist      <= '0;
         r_fill      <= '0;
         r_count     <= '0;
         r_word      <= '0;
         r_bit_idx   <= '0;
         r_match     <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_match <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // cfg_load and an accept in the same cycle both apply; the
               // new pattern and cleared history govern the accepted word.
               if (bus.cfg_load) begin
                  r_pattern <= bus.cfg_pattern;
                  r_hist    <= '0;
                  r_fill    <= '0;
               end
               if (w_accept) begin
                  r_word    <= bus.in_data;
                  r_count   <= '0;
                  r_bit_idx <= IDX_W'(WORD_W - 1);
                  r_busy    <= 1'b1;
                  r_state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_hist  <= w_next_hist;
               r_fill  <= w_next_fill;
               r_match <= w_hit;
               if (w_hit) r_count <= r_count + CNT_W'(1);
               if (r_bit_idx == '0) begin
                  r_out_valid <= 1'b1;
                  r_state     <= S_REPORT;
               end else begin
                  r_bit_idx <= r_bit_idx - IDX_W'(1);
               end
            end
            S_REPORT: begin
               // r_count is left untouched so out_count stays stable until
               // the next accepted word.
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pattern_scan_ctrl
// Directed bench for pattern_scan_ctrl (WORD_W=8, PAT_W=4, CNT_W=4) with
// hand-computed match counts and per-bit match masks.
// ---------------------------------------------------------------------------
module tb_pattern_scan_ctrl;
   logic clk;
   logic n_rst;
   int   n_chk;
   int   n_pass;

   pattern_scan_ctrl_if #(.WORD_W(8), .PAT_W(4), .CNT_W(4)) bus ();

   pattern_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(4)) u_dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      #7;
      n_rst = 1'b1;
      tick();
   endtask

   // Sends one word and follows it through SHIFT and REPORT.
   //   cfg_same : pulse cfg_load with pat in the accept cycle
   //   cfg_mid  : pulse cfg_load with pat during SHIFT (must be ignored)
   //   hold     : cycles out_ready stays low in REPORT
   // mask bit n-1 is the expected match flag after bit n.
   task automatic do_word(input string tag, input logic [7:0] d, input logic [3:0] exp_cnt,
                          input logic [7:0] exp_mask, input bit cfg_same, input bit cfg_mid,
                          input logic [3:0] pat, input int hold);
      logic [7:0] mask;
      int         w;
      w = 0;
      while (!bus.in_ready && w < 50) begin
         tick();
         w++;
      end
      check({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
      bus.in_data     = d;
      bus.in_valid    = 1'b1;
      bus.cfg_load    = cfg_same;
      bus.cfg_pattern = pat;
      bus.out_ready   = (hold == 0);
      tick();
      bus.in_valid = 1'b0;
      bus.cfg_load = 1'b0;
      check({tag, "_busy"}, {30'd0, bus.busy, bus.in_ready}, 32'd2);
      mask = '0;
      for (int n = 1; n <= 8; n++) begin
         if (cfg_mid && n == 2) begin
            bus.cfg_load    = 1'b1;
            bus.cfg_pattern = pat;
         end
         tick();
         bus.cfg_load = 1'b0;
         mask[n-1]    = bus.match;
         if (n < 8) check({tag, "_novld"}, {31'd0, bus.out_valid}, 32'd0);
      end
      check({tag, "_vld"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, "_cnt"}, {28'd0, bus.out_count}, {28'd0, exp_cnt});
      check({tag, "_mask"}, {24'd0, mask}, {24'd0, exp_mask});
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'hFF;
         tick();
         check({tag, "_stall"}, {26'd0, bus.out_valid, bus.in_ready, bus.busy, bus.match, bus.out_count},
               {26'd0, 1'b1, 1'b0, 1'b1, 1'b0, exp_cnt});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check({tag, "_idle"}, {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
      check({tag, "_keep"}, {28'd0, bus.out_count}, {28'd0, exp_cnt});
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      bus.cfg_load    = 1'b0;
      bus.cfg_pattern = '0;
      bus.in_valid    = 1'b0;
      bus.in_data     = '0;
      bus.out_ready   = 1'b1;
      n_rst = 1'b1;
      #2;
      n_rst = 1'b0;
      #1;
      check("rst_outs", {29'd0, bus.out_valid, bus.match, bus.busy}, 32'd0);
      check("rst_cnt", {28'd0, bus.out_count}, 32'd0);
      #5;
      n_rst = 1'b1;
      tick();
      check("rst_rdy", {31'd0, bus.in_ready}, 32'd1);

      // default pattern 1101
      do_word("basic", 8'b1101_1010, 4'd2, 8'h48, 1'b0, 1'b0, 4'h0, 0);
      do_word("ovl", 8'b1101_1011, 4'd2, 8'h48, 1'b0, 1'b0, 4'h0, 0);

      // match spanning the word boundary
      do_reset();
      do_word("xw1", 8'b0000_0110, 4'd0, 8'h00, 1'b0, 1'b0, 4'h0, 0);
      do_word("xw2", 8'b1000_0000, 4'd1, 8'h01, 1'b0, 1'b0, 4'h0, 0);

      // reconfigure in IDLE: clears history, so bits 4..8 match
      bus.cfg_load    = 1'b1;
      bus.cfg_pattern = 4'b0000;
      tick();
      bus.cfg_load = 1'b0;
      do_word("cfg0", 8'h00, 4'd5, 8'hF8, 1'b0, 1'b0, 4'h0, 0);
      // cfg_load during SHIFT ignored: history full of zeros, every bit hits
      do_word("cfgmid", 8'h00, 4'd8, 8'hFF, 1'b0, 1'b1, 4'hF, 0);

      // cfg_load + accept in one cycle, then 5-cycle backpressure
      do_word("bp", 8'b1101_1010, 4'd2, 8'h48, 1'b1, 1'b0, 4'b1101, 5);

      // reset mid-SHIFT
      bus.in_data  = 8'b1101_1101;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      tick();
      #2;
      n_rst = 1'b0;
      #1;
      check("mrst_outs", {28'd0, bus.out_valid, bus.match, bus.busy, bus.in_ready}, 32'b0001);
      #3;
      n_rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.out_valid) check("mrst_novld", 32'd1, 32'd0);
      end
      check("mrst_cnt", {28'd0, bus.out_count}, 32'd0);
      do_word("mrst", 8'b0000_1101, 4'd1, 8'h80, 1'b0, 1'b0, 4'h0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
